// File: rtl/sram_port_arbiter.sv
// Two-port req/gnt arbiter in front of a single-port synchronous SRAM macro.
// Optional build macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin contention instead of fixed priority.
module sram_port_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_di,
    output logic          mem_web,
    input  logic [DW-1:0] mem_do,
    output logic          busy
);

    logic          lock_valid;
    logic          lock_port;
    logic          sel1;
    logic          acc;
    logic          acc_port;
    logic          acc_we;
    logic          acc_lock;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          owner_req;
    logic          owner_lock;
    logic          iss_valid;
    logic          rd1_valid;
    logic          rd1_port;
    logic          rd2_valid;
    logic          rd2_port;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic          prio;
`endif

    // Contention winner: lock owner first, otherwise the priority choice.
    always_comb begin
        sel1 = 1'b0;
        if (lock_valid) begin
            sel1 = lock_port;
        end else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            sel1 = prio;
`else
            sel1 = 1'b0;
`endif
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = !sel1;
                gnt1 = sel1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign acc        = gnt0 | gnt1;
    assign acc_port   = gnt1;
    assign acc_we     = gnt1 ? we1    : we0;
    assign acc_lock   = gnt1 ? lock1  : lock0;
    assign acc_addr   = gnt1 ? addr1  : addr0;
    assign acc_wdata  = gnt1 ? wdata1 : wdata0;
    assign owner_req  = lock_port ? req1  : req0;
    assign owner_lock = lock_port ? lock1 : lock0;

    // Issue stage: register macro pins from the accepted port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_a     <= '0;
            mem_di    <= '0;
            mem_web   <= 1'b1;
            iss_valid <= 1'b0;
        end else begin
            mem_web   <= !(acc && acc_we);
            mem_di    <= acc ? acc_wdata : '0;
            iss_valid <= acc;
            if (acc) begin
                mem_a <= acc_addr;
            end
        end
    end

    // Read-source record follows the SRAM latency and steers returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_valid <= 1'b0;
            rd1_port  <= 1'b0;
            rd2_valid <= 1'b0;
            rd2_port  <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rd1_valid <= acc && !acc_we;
            rd1_port  <= acc_port;
            rd2_valid <= rd1_valid;
            rd2_port  <= rd1_port;
            rvalid0   <= rd2_valid && !rd2_port;
            rvalid1   <= rd2_valid && rd2_port;
            if (rd2_valid && !rd2_port) begin
                rdata0 <= mem_do;
            end
            if (rd2_valid && rd2_port) begin
                rdata1 <= mem_do;
            end
        end
    end

    // Lock ownership: taken on a locked acceptance, dropped once the owner lets go.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_valid <= 1'b0;
            lock_port  <= 1'b0;
        end else if (acc && acc_lock) begin
            lock_valid <= 1'b1;
            lock_port  <= acc_port;
        end else if (lock_valid && (!owner_req || !owner_lock)) begin
            lock_valid <= 1'b0;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Prefer the port that was not granted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (acc) begin
            prio <= !acc_port;
        end
    end
`endif

    assign busy = iss_valid | rd1_valid | rd2_valid;

endmodule
